// File: rtl/adc_spi_capture_pkg.sv
// adc_defs: shared constants, FSM encodings and code-conversion helpers for
// the adc_spi_capture front end (ADCS7476-style 16-bit frames).
package adc_defs;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_BITS  = 12;
    localparam int unsigned MID_CODE   = 2048;
    localparam int unsigned SAMPLE_W   = 25;
    localparam int unsigned STATE_W    = 2;
    localparam int unsigned EDGE_W     = 5;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_SHIFT = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

    // Offset-binary data field -> centred two's complement, shifted left.
    // Modular subtraction at SAMPLE_W bits yields the sign-extended result.
    function automatic logic [SAMPLE_W-1:0] to_sample(
        input logic [FRAME_BITS-1:0] frame,
        input int unsigned           sh
    );
        logic [SAMPLE_W-1:0] centred;
        centred = SAMPLE_W'(frame[DATA_BITS-1:0]) - SAMPLE_W'(MID_CODE);
        return centred << sh;
    endfunction

    // True when the leading (non-data) bits of a frame are all zero.
    function automatic logic lead_clear(input logic [FRAME_BITS-1:0] frame);
        return frame[FRAME_BITS-1:DATA_BITS] == '0;
    endfunction

endpackage

// File: rtl/adc_spi_capture_sclk_gen.sv
// adc_sclk_gen: serial clock generator for one ADC frame.
// Ports:
//   clk, rst   - system clock, async active-high reset
//   start      - frame start: force sclk low and clear counters
//   run        - frame in progress; sclk toggles every HALF_DIV clks
//   sclk       - registered serial clock, idles high
//   rise_c     - high in the cycle whose closing edge drives sclk 0->1
//   last_c     - high in the cycle whose closing edge ends the frame
//                (the would-be falling edge after the 16th rise)
module adc_sclk_gen
    import adc_defs::*;
#(
    parameter int unsigned HALF_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic sclk,
    output logic rise_c,
    output logic last_c
);

    localparam int unsigned HC_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [HC_W-1:0]   hcnt;
    logic [EDGE_W-1:0] edges;
    logic              half_tick;

    assign half_tick = run && (hcnt == HC_W'(HALF_DIV - 1));
    assign rise_c    = half_tick && !sclk;
    assign last_c    = half_tick && sclk && (edges == EDGE_W'(FRAME_BITS));

    // Half-period divider, sclk toggle and rising-edge count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk  <= 1'b1;
            hcnt  <= '0;
            edges <= '0;
        end else if (start) begin
            sclk  <= 1'b0;
            hcnt  <= '0;
            edges <= '0;
        end else if (run) begin
            if (half_tick) begin
                hcnt <= '0;
                // The final falling edge is replaced by the return to idle.
                sclk <= last_c ? 1'b1 : ~sclk;
                if (rise_c) begin
                    edges <= edges + EDGE_W'(1);
                end
            end else begin
                hcnt <= hcnt + HC_W'(1);
            end
        end else begin
            sclk  <= 1'b1;
            hcnt  <= '0;
            edges <= '0;
        end
    end

endmodule

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: drives a 12-bit serial ADC at a fixed frame rate,
// converts each offset-binary code to a 25-bit signed sample and strobes it.
// Ports:
//   clk, rst   - system clock, async active-high reset
//   miso       - ADC serial data, captured on sclk rising edges, MSB first
//   sclk       - ADC serial clock (idles high)
//   cs_n       - ADC chip select, active low
//   u          - signed sample, held between strobes
//   rx         - one-clk strobe marking a new u
//   frame_err  - one-clk flag for a dropped frame (ADC_FRAME_CHECK_EN only)
// Optional feature: define ADC_FRAME_CHECK_EN to drop frames whose four
// leading bits are not zero and report them on frame_err.
module adc_spi_capture
    import adc_defs::*;
#(
    parameter int unsigned HALF_DIV      = 1,
    parameter int unsigned SAMPLE_PERIOD = 64,
    parameter int unsigned SHIFT         = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                miso,
    output logic                sclk,
    output logic                cs_n,
    output logic [SAMPLE_W-1:0] u,
    output logic                rx
`ifdef ADC_FRAME_CHECK_EN
    ,
    output logic                frame_err
`endif
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_PERIOD);

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      period_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] shreg_next;
    logic [SAMPLE_W-1:0]   u_next;
    logic                  rx_next;
    logic                  cs_n_next;
    logic                  start_c;
    logic                  run_c;
    logic                  rise_c;
    logic                  last_c;
`ifdef ADC_FRAME_CHECK_EN
    logic                  err_next;
`endif

    assign start_c = (state == ST_IDLE) && (period_cnt == '0);
    assign run_c   = (state == ST_SHIFT);

    adc_sclk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .start  (start_c),
        .run    (run_c),
        .sclk   (sclk),
        .rise_c (rise_c),
        .last_c (last_c)
    );

    // State, period counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            period_cnt <= '0;
            shreg      <= '0;
            cs_n       <= 1'b1;
            u          <= '0;
            rx         <= 1'b0;
`ifdef ADC_FRAME_CHECK_EN
            frame_err  <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            period_cnt <= (period_cnt == CNT_W'(SAMPLE_PERIOD - 1))
                          ? '0 : period_cnt + CNT_W'(1);
            shreg      <= shreg_next;
            cs_n       <= cs_n_next;
            u          <= u_next;
            rx         <= rx_next;
`ifdef ADC_FRAME_CHECK_EN
            frame_err  <= err_next;
`endif
        end
    end

    // Next-state, capture and conversion.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        u_next     = u;
        rx_next    = 1'b0;
`ifdef ADC_FRAME_CHECK_EN
        err_next   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (period_cnt == '0) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rise_c) begin
                    shreg_next = {shreg[FRAME_BITS-2:0], miso};
                end
                if (last_c) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
`ifdef ADC_FRAME_CHECK_EN
                if (lead_clear(shreg)) begin
                    u_next  = to_sample(shreg, SHIFT);
                    rx_next = 1'b1;
                end else begin
                    err_next = 1'b1;
                end
`else
                u_next  = to_sample(shreg, SHIFT);
                rx_next = 1'b1;
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        cs_n_next = (state_next != ST_SHIFT);
    end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Scoreboard bench for adc_spi_capture: instance 0 uses the default
// parameters, instance 1 uses HALF_DIV=3, SAMPLE_PERIOD=128.
module tb_adc_spi_capture;

    localparam int SHIFT_P = 4;

    typedef struct packed {
        logic        err;
        logic [24:0] u;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miso_a [2] = '{1'b0, 1'b0};
    logic        cs_n_a [2];
    logic        sclk_a [2];
    logic        rx_a   [2];
    logic        ferr_a [2];
    logic [24:0] u_a    [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [15:0] stim_q [$];
    logic [24:0] last_u [2] = '{25'd0, 25'd0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_spi_capture #(.HALF_DIV(1), .SAMPLE_PERIOD(64), .SHIFT(SHIFT_P)) dut0 (
        .clk (clk), .rst (rst), .miso (miso_a[0]), .sclk (sclk_a[0]),
        .cs_n (cs_n_a[0]), .u (u_a[0]), .rx (rx_a[0])
`ifdef ADC_FRAME_CHECK_EN
        , .frame_err (ferr_a[0])
`endif
    );

    adc_spi_capture #(.HALF_DIV(3), .SAMPLE_PERIOD(128), .SHIFT(SHIFT_P)) dut1 (
        .clk (clk), .rst (rst), .miso (miso_a[1]), .sclk (sclk_a[1]),
        .cs_n (cs_n_a[1]), .u (u_a[1]), .rx (rx_a[1])
`ifdef ADC_FRAME_CHECK_EN
        , .frame_err (ferr_a[1])
`endif
    );

`ifndef ADC_FRAME_CHECK_EN
    assign ferr_a[0] = 1'b0;
    assign ferr_a[1] = 1'b0;
`endif

    function automatic int hd(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int sp(input int i);
        return (i == 0) ? 64 : 128;
    endfunction

    // Reference conversion: (code - mid-scale) * 2^SHIFT in 25-bit two's complement.
    function automatic logic [24:0] model(input logic [11:0] code);
        int v;
        v = int'(code) - 2048;
        v = v * (2 ** SHIFT_P);
        return v[24:0];
    endfunction

    function void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function void push_exp(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function bit pop_exp(input int i, output exp_t e);
        e = '0;
        if (i == 0) begin
            if (q0.size() == 0) return 1'b0;
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) return 1'b0;
            e = q1.pop_front();
        end
        return 1'b1;
    endfunction

    // ADC model: loads a frame when cs_n falls, advances on sclk falls,
    // and pushes the expected response for each frame it serves.
    logic m_pcs   [2] = '{1'b1, 1'b1};
    logic m_psclk [2] = '{1'b1, 1'b1};
    int   m_idx   [2] = '{0, 0};
    logic [15:0] m_frame [2];

    always @(posedge clk) begin
        logic [15:0] f;
        exp_t        e;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (m_pcs[i] && !cs_n_a[i]) begin
                if (i == 0 && stim_q.size() > 0) begin
                    f = stim_q.pop_front();
                end else begin
                    f = 16'($urandom_range(0, 4095));
                    if ($urandom_range(0, 7) == 0) f[15:12] = 4'($urandom_range(1, 15));
                end
                m_frame[i] = f;
                m_idx[i]   = 15;
                miso_a[i]  = f[15];
`ifdef ADC_FRAME_CHECK_EN
                if (f[15:12] != 4'd0) begin
                    e.err = 1'b1;
                    e.u   = last_u[i];
                end else begin
                    e.err = 1'b0;
                    e.u   = model(f[11:0]);
                    last_u[i] = e.u;
                end
`else
                e.err = 1'b0;
                e.u   = model(f[11:0]);
                last_u[i] = e.u;
`endif
                push_exp(i, e);
            end else if (!cs_n_a[i] && m_psclk[i] && !sclk_a[i] && m_idx[i] > 0) begin
                m_idx[i]  = m_idx[i] - 1;
                miso_a[i] = m_frame[i][m_idx[i]];
            end
            m_pcs[i]   = cs_n_a[i];
            m_psclk[i] = sclk_a[i];
        end
    end

    // Monitor: samples on the falling clk edge, checks frame timing and
    // pops the scoreboard on every rx or frame_err.
    logic        pcs   [2] = '{1'b1, 1'b1};
    logic        psclk [2] = '{1'b1, 1'b1};
    logic        prx   [2] = '{1'b0, 1'b0};
    logic        pferr [2] = '{1'b0, 1'b0};
    logic [24:0] pu    [2] = '{25'd0, 25'd0};
    int          fall_cyc [2] = '{0, 0};
    int          rises    [2] = '{0, 0};
    int          last_rise[2] = '{-1, -1};
    int          last_evt [2] = '{0, 0};
    int          since_evt[2] = '{0, 0};
    int          events   [2] = '{0, 0};
    bit          have_evt [2] = '{1'b0, 1'b0};
    bit          in_frame [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                in_frame[i]  = 1'b0;
                have_evt[i]  = 1'b0;
                rises[i]     = 0;
                since_evt[i] = 0;
            end else begin
                if (pcs[i] && !cs_n_a[i]) begin
                    fall_cyc[i]  = cyc;
                    rises[i]     = 0;
                    last_rise[i] = -1;
                    in_frame[i]  = 1'b1;
                end
                if (!cs_n_a[i] && sclk_a[i] && !psclk[i]) begin
                    rises[i]++;
                    if (last_rise[i] >= 0) chk("sclk_period", 32'(cyc - last_rise[i]), 32'(2 * hd(i)));
                    last_rise[i] = cyc;
                end
                if (!pcs[i] && cs_n_a[i] && in_frame[i]) begin
                    chk("sclk_rises", 32'(rises[i]), 32'd16);
                    chk("cs_low_len", 32'(cyc - fall_cyc[i]), 32'(32 * hd(i)));
                    in_frame[i] = 1'b0;
                end
                if (rx_a[i] || ferr_a[i]) begin
                    events[i]++;
                    since_evt[i] = 0;
                    chk("latency", 32'(cyc - fall_cyc[i]), 32'(32 * hd(i) + 1));
                    if (have_evt[i]) chk("spacing", 32'(cyc - last_evt[i]), 32'(sp(i)));
                    have_evt[i] = 1'b1;
                    last_evt[i] = cyc;
                    chk("one_clk", 32'(prx[i] | pferr[i]), 32'd0);
                    if (pop_exp(i, e)) begin
                        chk("kind_err", 32'(ferr_a[i]), 32'(e.err));
                        chk("kind_rx", 32'(rx_a[i]), 32'(!e.err));
                        chk("u_value", 32'(u_a[i]), 32'(e.u));
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: inst %0d got strobe with u=%h, required none", i, u_a[i]);
                    end
                end else begin
                    since_evt[i]++;
                    chk("u_hold", 32'(u_a[i]), 32'(pu[i]));
                    if (since_evt[i] > sp(i) + 40) begin
                        checks++;
                        errors++;
                        $display("FAIL strobe_timeout: inst %0d got no strobe for %0d clks, required %0d", i, since_evt[i], sp(i));
                        since_evt[i] = 0;
                    end
                end
            end
            pcs[i]   = cs_n_a[i];
            psclk[i] = sclk_a[i];
            prx[i]   = rx_a[i];
            pferr[i] = ferr_a[i];
            pu[i]    = u_a[i];
        end
    end

    initial begin
        bit found;
        stim_q.push_back(16'h0800);
        stim_q.push_back(16'h0FFF);
        stim_q.push_back(16'h0000);
        stim_q.push_back(16'h0801);
`ifdef ADC_FRAME_CHECK_EN
        stim_q.push_back(16'h2123);
        stim_q.push_back(16'h0ABC);
`endif
        stim_q.push_back(16'h07FF);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs_n", 32'(cs_n_a[i]), 32'd1);
            chk("rst_sclk", 32'(sclk_a[i]), 32'd1);
            chk("rst_u", 32'(u_a[i]), 32'd0);
            chk("rst_rx", 32'(rx_a[i]), 32'd0);
            chk("rst_ferr", 32'(ferr_a[i]), 32'd0);
        end
        #1 rst = 1'b0;
        @(posedge clk);
        #2;
        chk("first_edge_cs_n", 32'(cs_n_a[0]), 32'd0);
        chk("first_edge_sclk", 32'(sclk_a[0]), 32'd0);

        repeat (1400) @(negedge clk);

        // Reset in the middle of a frame, just after the 8th sclk rise.
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            #1;
            if (rises[0] == 8 && !cs_n_a[0]) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL mid_frame_wait: got no 8th sclk rise within 200 clks, required one");
        end
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_rst_cs_n", 32'(cs_n_a[i]), 32'd1);
            chk("async_rst_sclk", 32'(sclk_a[i]), 32'd1);
            chk("async_rst_u", 32'(u_a[i]), 32'd0);
            chk("async_rst_rx", 32'(rx_a[i]), 32'd0);
        end
        q0.delete();
        q1.delete();
        last_u[0] = 25'd0;
        last_u[1] = 25'd0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("restart_cs_n", 32'(cs_n_a[i]), 32'd0);
            chk("restart_sclk", 32'(sclk_a[i]), 32'd0);
        end

        repeat (700) @(negedge clk);
        #1;
        chk("events_inst0", 32'(events[0] >= 28), 32'd1);
        chk("events_inst1", 32'(events[1] >= 13), 32'd1);
        chk("pending_inst0", 32'(q0.size() <= 1), 32'd1);
        chk("pending_inst1", 32'(q1.size() <= 1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_spi_capture.md
# adc_spi_capture

Front-end stage feeding `pasabajas_200`. It drives a 12-bit serial ADC (ADCS7476-style frame: 4 leading zeros followed by 12 data bits, MSB first), converts each offset-binary code into the 25-bit signed sample `u`, and marks each new sample with a one-cycle `rx` strobe at a fixed sample rate. Its `u`/`rx` outputs connect directly to the filter's `u`/`rx` inputs.

## Interface
- `HALF_DIV`, 1: clk cycles per SCLK half-period (≥1).
- `SAMPLE_PERIOD`, 64: clk cycles between frame starts; must be ≥ 32·HALF_DIV+4 and ≥16 (the filter's minimum strobe spacing).
- `SHIFT`, 4: left shift applied to the centred code (0..12).
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-high reset.
- `miso` in 1: ADC serial data.
- `sclk` out 1: ADC serial clock; idles high.
- `cs_n` out 1: ADC chip select, active low.
- `u` out 25: signed two's-complement sample to the filter.
- `rx` out 1: one-cycle strobe; `u` is valid and new while it is high.
- `frame_err` out 1: present only with the macro (see Configuration).

## Operation
- FSM states: IDLE (`cs_n`=1, waiting on the period counter), SHIFT (`cs_n`=0, clocking 16 bits), DONE (`cs_n`=1, update `u`, pulse `rx`), then back to IDLE.
- The period counter runs freely from 0 to SAMPLE_PERIOD−1 and wraps. IDLE moves to SHIFT when the count is 0.
- During SHIFT, `sclk` toggles every HALF_DIV clks, starting low.
- `miso` is captured into a 16-bit shift register on the clk edge where `sclk` goes 0→1. Bits are MSB first.
- After the 16th capture:
  - code = `shreg[11:0]`.
  - `u` = sign-extend-to-25(code − 2048) <<< SHIFT, giving a range of −2048·2^SHIFT to +2047·2^SHIFT. There is no overflow for SHIFT ≤ 12.
- `u` holds its value between strobes.
- Reset values: `cs_n`=1, `sclk`=1, `u`=0, `rx`=0, `frame_err`=0, period counter 0, state IDLE, shift register 0.
- Reset asserted mid-frame aborts immediately: the partial frame is discarded and `u` is cleared to 0.

## Timing
- E0 is the clk edge where `cs_n` goes low. After reset release, E0 is the first rising clk edge.
- At E0, `sclk` goes low.
- `sclk` rises at E0+(2k+1)·HALF_DIV and falls at E0+(2k+2)·HALF_DIV, for k=0..15.
- At E0+32·HALF_DIV, `cs_n` goes to 1 and `sclk` goes to 1.
- At E0+32·HALF_DIV+1, `u` is updated and `rx`=1. At the following edge, `rx`=0.
- Latency from `cs_n` falling to `rx` is 32·HALF_DIV+1 clks.
- `rx` pulses exactly SAMPLE_PERIOD clks apart, with no jitter.
- A frame-start condition during SHIFT or DONE cannot occur, because of the SAMPLE_PERIOD constraint.

## Configuration
- Macro: `ADC_FRAME_CHECK_EN`.
- Defined:
  - `frame_err` port exists.
  - If `shreg[15:12]` ≠ 0 after the 16th bit, the frame is dropped: no `rx`, `u` is unchanged, and `frame_err` is 1 for one clk in the cycle where `rx` would have been high.
- Undefined:
  - Leading bits are ignored and every frame produces `rx`.
  - No `frame_err` port.

## Structure
- A shared definitions package/include `adc_defs` holds:
  - FRAME_BITS=16, DATA_BITS=12, MID_CODE=2048, SAMPLE_W=25.
  - FSM state encodings IDLE/SHIFT/DONE.
- One sub-module, `adc_sclk_gen`:
  - Counts HALF_DIV and toggles `sclk`.
  - Outputs a `rise` tick and a 16-edge `last` flag.
  - The top level holds the FSM, period counter, shift register and conversion.

## Test plan
Defaults unless stated: HALF_DIV=1, SAMPLE_PERIOD=64, SHIFT=4. The bench ADC model drives `miso` on `sclk` falling edges.
- Code 0x800 → `u`=0. `rx` high exactly 33 clks after `cs_n` falls, for one clk only.
- Code 0xFFF → `u`=0x0007FF0. Code 0x000 → `u`=0x1FF8000 (−32768). Code 0x801 → `u`=0x0000010.
- Free run of 10 frames → `rx` spacing 64 clks, 16 `sclk` rising edges per `cs_n`-low window, `cs_n` low for 32 clks.
- `rst` asserted after the 8th `sclk` rise → `cs_n`=1, `sclk`=1, `u`=0, `rx`=0 without waiting for a clk edge. After release, the first frame starts on the first edge and completes all 16 bits.
- With `ADC_FRAME_CHECK_EN`: leading nibble 0b0010 with code 0x123 → no `rx`, one-clk `frame_err`, `u` keeps its previous value. The next clean frame restores normal `rx`.
- HALF_DIV=3, SAMPLE_PERIOD=128 → `sclk` period 6 clks, `rx` 97 clks after `cs_n` falls, strobes 128 clks apart.
